// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the non-FWFT DPRAM FIFO: issues reads, absorbs the
// one-cycle RAM latency and re-presents words on a valid/ready stream.
module fifo_stream_reader #(
  parameter int WIDTH = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Enable,
  output logic             o_Rd_En,
  input  logic             i_Empty,
  input  logic             i_Rd_DV,
  input  logic [WIDTH-1:0] i_Rd_Data,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Data,
  input  logic             i_Ready,
  output logic [1:0]       o_Level,
  output logic             o_Err
);

  logic [1:0]       buf_cnt, buf_cnt_nxt;
  logic [WIDTH-1:0] head_q, head_nxt;
  logic [WIDTH-1:0] tail_q, tail_nxt;
  logic             inflight;
  logic             valid_q;
  logic             err_q, err_nxt;
  logic             pop, push;
  logic [1:0]       occ;

  assign pop  = valid_q & i_Ready;
  assign push = i_Rd_DV & inflight;
  assign occ  = buf_cnt + {1'b0, inflight};

  // A pop this cycle frees a slot, so a read may issue even at full occupancy.
  assign o_Rd_En = i_Enable & ~i_Empty & ~i_Rst & ((occ < 2'd2) | pop);

  always_comb begin
    buf_cnt_nxt = buf_cnt;
    head_nxt    = head_q;
    tail_nxt    = tail_q;
    err_nxt     = err_q | (i_Rd_DV & ~inflight) | (inflight & ~i_Rd_DV);
    case ({push, pop})
      2'b10: begin
        case (buf_cnt)
          2'd0: begin
            head_nxt    = i_Rd_Data;
            buf_cnt_nxt = 2'd1;
          end
          2'd1: begin
            tail_nxt    = i_Rd_Data;
            buf_cnt_nxt = 2'd2;
          end
          default: err_nxt = 1'b1;
        endcase
      end
      2'b01: begin
        head_nxt    = tail_q;
        buf_cnt_nxt = buf_cnt - 2'd1;
      end
      2'b11: begin
        if (buf_cnt == 2'd2) begin
          head_nxt = tail_q;
          tail_nxt = i_Rd_Data;
        end else begin
          head_nxt = i_Rd_Data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      buf_cnt  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      inflight <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      buf_cnt  <= buf_cnt_nxt;
      head_q   <= head_nxt;
      tail_q   <= tail_nxt;
      inflight <= o_Rd_En;
      valid_q  <= (buf_cnt_nxt != 2'd0);
      err_q    <= err_nxt;
    end
  end

  assign o_Valid = valid_q;
  assign o_Data  = head_q;
  assign o_Level = buf_cnt;
  assign o_Err   = err_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboarded bench: a queue-based FIFO model feeds the reader, expected
// words are queued at write time and a negedge monitor checks the stream.
module tb_fifo_stream_reader;

  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_Enable = 1'b0;
  logic       o_Rd_En;
  logic       i_Empty = 1'b1;
  logic       i_Rd_DV = 1'b0;
  logic [7:0] i_Rd_Data = '0;
  logic       o_Valid;
  logic [7:0] o_Data;
  logic       i_Ready = 1'b0;
  logic [1:0] o_Level;
  logic       o_Err;

  fifo_stream_reader #(.WIDTH(8)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enable(i_Enable), .o_Rd_En(o_Rd_En),
    .i_Empty(i_Empty), .i_Rd_DV(i_Rd_DV), .i_Rd_Data(i_Rd_Data),
    .o_Valid(o_Valid), .o_Data(o_Data), .i_Ready(i_Ready),
    .o_Level(o_Level), .o_Err(o_Err)
  );

  always #5 i_Clk = ~i_Clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int err_exp = 0;
  int infl = 0;
  int rd_s = 0;
  int pv_valid = 0, pv_ready = 0, pv_data = 0;
  int cyc = 0, rd_count = 0, rd_run = 0, rd_max = 0, first_rd = -1;
  int val_count = 0, val_run = 0, val_max = 0, first_val = -1;
  int pop_count = 0;

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void clr_stats();
    rd_count = 0; rd_run = 0; rd_max = 0; first_rd = -1;
    val_count = 0; val_run = 0; val_max = 0; first_val = -1;
    pop_count = 0;
  endfunction

  function automatic void wr(logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    i_Empty = 1'b0;
  endfunction

  // One clock: sample/check at negedge, then model the FIFO read port after posedge.
  task automatic cycle();
    @(negedge i_Clk);
    rd_s = int'(o_Rd_En);
    if (i_Rst) begin
      chk("rd_en_in_reset", int'(o_Rd_En), 0);
      infl = 0;
      pv_valid = 0;
    end else begin
      chk("occupancy_le2", int'((int'(o_Level) + infl) <= 2), 1);
      chk("valid_vs_level", int'(o_Valid), int'(o_Level != 2'd0));
      chk("err_flag", int'(o_Err), err_exp);
      if (pv_valid != 0 && pv_ready == 0) begin
        chk("hold_valid", int'(o_Valid), 1);
        chk("hold_data", int'(o_Data), pv_data);
      end
      if (rd_s != 0) begin
        rd_count++; rd_run++;
        if (first_rd < 0) first_rd = cyc;
      end else rd_run = 0;
      if (rd_run > rd_max) rd_max = rd_run;
      if (o_Valid) begin
        val_count++; val_run++;
        if (first_val < 0) first_val = cyc;
      end else val_run = 0;
      if (val_run > val_max) val_max = val_run;
      pv_valid = int'(o_Valid);
      pv_ready = int'(i_Ready);
      pv_data  = int'(o_Data);
      infl = rd_s;
    end
    cyc++;
    @(posedge i_Clk);
    #1;
    i_Rd_DV = 1'b0;
    if (rd_s != 0) begin
      if (fifo_q.size() == 0) chk("fifo_underflow", 1, 0);
      else begin
        i_Rd_Data = fifo_q.pop_front();
        i_Rd_DV = 1'b1;
      end
    end
    i_Empty = (fifo_q.size() == 0);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      cycle();
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    run(3);
  endtask

  always @(negedge i_Clk) begin
    if (!i_Rst && o_Valid && i_Ready) begin
      if (exp_q.size() == 0) chk("extra_word", int'(o_Data), -1);
      else begin
        chk("stream_data", int'(o_Data), int'(exp_q.pop_front()));
        pop_count++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #2;
    chk("rst_valid", int'(o_Valid), 0);
    chk("rst_data", int'(o_Data), 0);
    chk("rst_level", int'(o_Level), 0);
    chk("rst_err", int'(o_Err), 0);
    run(2);
    i_Rst = 1'b0;
    i_Enable = 1'b1;
    i_Ready = 1'b1;
    run(2);

    // Single word latency
    clr_stats();
    wr(8'hA5);
    drain(20);
    chk("single_rd_count", rd_count, 1);
    chk("single_valid_cycles", val_count, 1);
    chk("single_latency", first_val - first_rd, 2);

    // 16-word burst at full throughput
    clr_stats();
    for (int i = 0; i < 16; i++) wr(8'(i));
    drain(60);
    chk("burst_rd_run", rd_max, 16);
    chk("burst_valid_run", val_max, 16);
    chk("burst_pops", pop_count, 16);

    // Backpressure: only two reads issue, head holds
    clr_stats();
    i_Ready = 1'b0;
    for (int i = 0; i < 8; i++) wr(8'(8'h10 + i));
    run(10);
    chk("bp_rd_count", rd_count, 2);
    chk("bp_level", int'(o_Level), 2);
    chk("bp_head", int'(o_Data), 8'h10);
    clr_stats();
    i_Ready = 1'b1;
    drain(40);
    chk("bp_valid_cycles", val_count, 8);
    chk("bp_valid_run", val_max, 8);

    // Ready toggling over a random 32-word burst
    clr_stats();
    for (int i = 0; i < 32; i++) wr(8'($urandom));
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
        i_Ready = ~i_Ready;
        cycle();
        n++;
      end
    end
    i_Ready = 1'b1;
    drain(20);
    chk("toggle_pops", pop_count, 32);

    // Enable dropped after the fifth read
    clr_stats();
    for (int i = 0; i < 10; i++) wr(8'($urandom));
    begin
      int n = 0;
      while (rd_count < 5 && n < 40) begin
        cycle();
        n++;
      end
    end
    i_Enable = 1'b0;
    run(6);
    chk("pause_rd_count", rd_count, 5);
    chk("pause_delivered", pop_count, 5);
    i_Enable = 1'b1;
    drain(40);
    chk("resume_delivered", pop_count, 10);

    // Random traffic
    clr_stats();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) wr(8'($urandom));
      i_Ready  = 1'($urandom_range(0, 1));
      i_Enable = ($urandom_range(0, 7) != 0);
      cycle();
    end
    i_Enable = 1'b1;
    i_Ready = 1'b1;
    drain(200);

    // Asynchronous reset with a full buffer
    i_Ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(8'(8'h60 + i));
    run(6);
    chk("pre_reset_level", int'(o_Level), 2);
    i_Rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(o_Valid), 0);
    chk("async_rst_level", int'(o_Level), 0);
    chk("async_rst_rd_en", int'(o_Rd_En), 0);
    fifo_q.delete();
    exp_q.delete();
    i_Rd_DV = 1'b0;
    i_Empty = 1'b1;
    err_exp = 0;
    run(2);
    i_Rst = 1'b0;
    i_Ready = 1'b1;
    run(3);

    // Spurious data-valid sets a sticky error
    i_Enable = 1'b0;
    i_Rd_DV = 1'b1;
    i_Rd_Data = 8'h77;
    cycle();
    err_exp = 1;
    run(5);
    chk("spurious_err", int'(o_Err), 1);
    chk("spurious_dropped", int'(o_Level), 0);
    i_Rst = 1'b1;
    #1;
    err_exp = 0;
    chk("err_cleared", int'(o_Err), 0);
    run(1);
    i_Rst = 1'b0;
    run(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
